// File: rtl/gpio_led_ctrl_if.sv
// rtl/gpio_led_ctrl_if.sv - register write/readback bus for gpio_led_ctrl
interface gpio_led_ctrl_if;
  logic        we;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output we, addr, wdata, input rdata);
  modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/gpio_led_ctrl.sv
// rtl/gpio_led_ctrl.sv - LED set/clear/toggle with blink prescaler, GPIO and counter select
// Optional register readback mux enabled by defining GPIO_LED_CTRL_READBACK_EN.
module gpio_led_ctrl #(
  parameter int LED_W  = 8,
  parameter int GPIO_W = 22,
  parameter int PRE_W  = 24
) (
  input  logic              clk,
  input  logic              reset,
  gpio_led_ctrl_if.slave    bus,
  output logic [LED_W-1:0]  led_out,
  output logic [1:0]        counter_set,
  output logic [GPIO_W-1:0] gpio_out
);

  localparam logic [2:0] A_LED_WR  = 3'd0;
  localparam logic [2:0] A_LED_SET = 3'd1;
  localparam logic [2:0] A_LED_CLR = 3'd2;
  localparam logic [2:0] A_LED_TGL = 3'd3;
  localparam logic [2:0] A_BLINK   = 3'd4;
  localparam logic [2:0] A_PERIOD  = 3'd5;
  localparam logic [2:0] A_GPIO    = 3'd6;

  logic [LED_W-1:0]  led_q;
  logic [LED_W-1:0]  blink_q;
  logic [PRE_W-1:0]  period_q;
  logic [1:0]        cset_q;
  logic [GPIO_W-1:0] gpio_q;
  logic [PRE_W-1:0]  cnt_q;
  logic              phase_q;

  logic [LED_W-1:0]  wr_led;
  logic [PRE_W-1:0]  wr_pre;
  logic              period_wr;

  assign wr_led    = bus.wdata[LED_W-1:0];
  assign wr_pre    = bus.wdata[PRE_W-1:0];
  assign period_wr = bus.we && (bus.addr == A_PERIOD);

  // All state advances on the falling edge of clk.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      led_q    <= '0;
      blink_q  <= '0;
      period_q <= '0;
      cset_q   <= '0;
      gpio_q   <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b1;
    end else begin
      if (bus.we) begin
        case (bus.addr)
          A_LED_WR:  led_q   <= wr_led;
          A_LED_SET: led_q   <= led_q | wr_led;
          A_LED_CLR: led_q   <= led_q & ~wr_led;
          A_LED_TGL: led_q   <= led_q ^ wr_led;
          A_BLINK:   blink_q <= wr_led;
          A_GPIO: begin
            cset_q <= bus.wdata[31:30];
            gpio_q <= bus.wdata[GPIO_W-1:0];
          end
          default: ;
        endcase
      end

      // A PERIOD write restarts the blink cycle and wins over reload/toggle.
      if (period_wr) begin
        period_q <= wr_pre;
        cnt_q    <= wr_pre;
        phase_q  <= 1'b1;
      end else if (period_q == '0) begin
        cnt_q    <= '0;
        phase_q  <= 1'b1;
      end else if (cnt_q == '0) begin
        cnt_q    <= period_q;
        phase_q  <= ~phase_q;
      end else begin
        cnt_q    <= cnt_q - PRE_W'(1);
      end
    end
  end

  assign led_out     = led_q & (~blink_q | {LED_W{phase_q}});
  assign counter_set = cset_q;
  assign gpio_out    = gpio_q;

`ifdef GPIO_LED_CTRL_READBACK_EN
  logic [31:0] rd;

  always_comb begin
    rd = '0;
    case (bus.addr)
      A_LED_WR, A_LED_SET, A_LED_CLR, A_LED_TGL: rd[LED_W-1:0] = led_q;
      A_BLINK:  rd[LED_W-1:0] = blink_q;
      A_PERIOD: rd[PRE_W-1:0] = period_q;
      A_GPIO: begin
        rd[GPIO_W-1:0] = gpio_q;
        rd[31:30]      = cset_q;
      end
      default: begin
        rd[PRE_W-1:0] = cnt_q;
        rd[31]        = phase_q;
      end
    endcase
  end

  assign bus.rdata = rd;
`else
  assign bus.rdata = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// tb/tb_gpio_led_ctrl.sv - scoreboard bench for gpio_led_ctrl against a behavioural model
module tb_gpio_led_ctrl;
  localparam int LED_W  = 8;
  localparam int GPIO_W = 22;
  localparam int PRE_W  = 24;

  logic              clk = 1'b1;
  logic              reset;
  logic [LED_W-1:0]  led_out;
  logic [1:0]        counter_set;
  logic [GPIO_W-1:0] gpio_out;

  gpio_led_ctrl_if bus ();

  gpio_led_ctrl #(.LED_W(LED_W), .GPIO_W(GPIO_W), .PRE_W(PRE_W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .led_out(led_out),
    .counter_set(counter_set),
    .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] led;
    logic [31:0] cset;
    logic [31:0] gpio;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model: registers plus the number of edges elapsed since the last PERIOD write.
  logic [7:0]  m_led, m_blink;
  logic [23:0] m_period;
  logic [1:0]  m_cset;
  logic [21:0] m_gpio;
  int          m_k;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%h expected=%h", name, got, exp);
    else n_pass++;
  endtask

  function automatic logic m_phase();
    if (m_period == 0) return 1'b1;
    return ((m_k / (int'(m_period) + 1)) % 2) == 0;
  endfunction

  function automatic logic [23:0] m_cnt();
    if (m_period == 0) return 24'd0;
    return 24'(int'(m_period) - (m_k % (int'(m_period) + 1)));
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] a);
`ifdef GPIO_LED_CTRL_READBACK_EN
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3: return {24'd0, m_led};
      3'd4: return {24'd0, m_blink};
      3'd5: return {8'd0, m_period};
      3'd6: return {m_cset, 8'd0, m_gpio};
      default: return {m_phase(), 7'd0, m_cnt()};
    endcase
`else
    return a == 3'd7 ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic model_reset();
    m_led = 0; m_blink = 0; m_period = 0; m_cset = 0; m_gpio = 0; m_k = 0;
  endtask

  task automatic model_edge(input logic we, input logic [2:0] a, input logic [31:0] d);
    if (reset) begin
      model_reset();
      return;
    end
    if (we && a == 3'd5) begin
      m_period = d[23:0];
      m_k = 0;
    end else if (m_period != 0) begin
      m_k++;
    end
    if (we) begin
      case (a)
        3'd0: m_led = d[7:0];
        3'd1: m_led = m_led | d[7:0];
        3'd2: m_led = m_led & ~d[7:0];
        3'd3: m_led = m_led ^ d[7:0];
        3'd4: m_blink = d[7:0];
        3'd6: begin m_cset = d[31:30]; m_gpio = d[21:0]; end
        default: ;
      endcase
    end
  endtask

  logic        cur_we;
  logic [2:0]  cur_addr;
  logic [31:0] cur_wdata;

  task automatic drive(input logic we, input logic [2:0] a, input logic [31:0] d);
    @(posedge clk);
    #2;
    bus.we = we; bus.addr = a; bus.wdata = d;
    cur_we = we; cur_addr = a; cur_wdata = d;
  endtask

  task automatic settle();
    exp_t e;
    @(negedge clk);
    model_edge(cur_we, cur_addr, cur_wdata);
    #1;
    e.led   = {24'd0, m_led & (~m_blink | {8{m_phase()}})};
    e.cset  = {30'd0, m_cset};
    e.gpio  = {10'd0, m_gpio};
    e.rdata = m_rdata(cur_addr);
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic we, input logic [2:0] a, input logic [31:0] d);
    drive(we, a, d);
    settle();
  endtask

  // Monitor: outputs settle after the falling edge and are compared on the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_led_out", {24'd0, led_out}, e.led);
        check("sb_counter_set", {30'd0, counter_set}, e.cset);
        check("sb_gpio_out", {10'd0, gpio_out}, e.gpio);
        check("sb_rdata", bus.rdata, e.rdata);
      end
    end
  end

  initial begin
    logic [2:0]  a;
    logic [31:0] d;
    int          wait_cyc;
    reset = 1'b1;
    bus.we = 1'b0; bus.addr = 3'd0; bus.wdata = 32'd0;
    cur_we = 1'b0; cur_addr = 3'd0; cur_wdata = 32'd0;
    model_reset();
    #1;
    check("reset_led_out", {24'd0, led_out}, 32'd0);
    check("reset_counter_set", {30'd0, counter_set}, 32'd0);
    check("reset_gpio_out", {10'd0, gpio_out}, 32'd0);
    cycle(1'b0, 3'd0, 32'd0);
    drive(1'b0, 3'd0, 32'd0);
    reset = 1'b0;
    settle();

    // LED write / set / clear / toggle
    cycle(1'b1, 3'd0, 32'h0000_00A5); check("led_write", {24'd0, led_out}, 32'hA5);
    cycle(1'b1, 3'd1, 32'h0000_000F); check("led_set", {24'd0, led_out}, 32'hAF);
    cycle(1'b1, 3'd2, 32'h0000_0081); check("led_clear", {24'd0, led_out}, 32'h2E);
    cycle(1'b1, 3'd3, 32'h0000_00FF); check("led_toggle", {24'd0, led_out}, 32'hD1);
    cycle(1'b1, 3'd7, 32'hFFFF_FFFF); check("addr7_ignored", {24'd0, led_out}, 32'hD1);

    // GPIO and counter select share one write
    cycle(1'b1, 3'd6, 32'hC012_3456);
    check("cset_load", {30'd0, counter_set}, 32'd3);
    check("gpio_load", {10'd0, gpio_out}, 32'h0012_3456);

    // Blink with PERIOD=3: four edges per half-period
    cycle(1'b1, 3'd0, 32'h0000_00FF);
    cycle(1'b1, 3'd4, 32'h0000_000F);
    cycle(1'b1, 3'd5, 32'd3);
    check("blink_k0", {24'd0, led_out}, 32'hFF);
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, 3'd0, 32'd0);
      check($sformatf("blink_k%0d", i), {24'd0, led_out}, ((i / 4) % 2 == 0) ? 32'hFF : 32'hF0);
    end
    cycle(1'b1, 3'd5, 32'd0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 3'd0, 32'd0);
      check("blink_off_steady", {24'd0, led_out}, 32'hFF);
    end

    // PERIOD write landing on the wrap edge must not toggle
    cycle(1'b1, 3'd5, 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 3'd0, 32'd0);
    cycle(1'b1, 3'd5, 32'd5);
    check("wrap_write_no_toggle", {24'd0, led_out}, 32'hFF);
    for (int i = 1; i <= 6; i++) begin
      cycle(1'b0, 3'd7, 32'd0);
      check($sformatf("wrap_write_k%0d", i), {24'd0, led_out}, (i < 6) ? 32'hFF : 32'hF0);
    end
`ifdef GPIO_LED_CTRL_READBACK_EN
    cycle(1'b1, 3'd5, 32'd3);
    drive(1'b0, 3'd7, 32'd0);
    #1 check("rb_cnt3", bus.rdata, 32'h8000_0003);
    settle(); check("rb_cnt2", bus.rdata, 32'h8000_0002);
    cycle(1'b0, 3'd7, 32'd0); check("rb_cnt1", bus.rdata, 32'h8000_0001);
    cycle(1'b0, 3'd7, 32'd0); check("rb_cnt0", bus.rdata, 32'h8000_0000);
    cycle(1'b0, 3'd7, 32'd0); check("rb_wrap", bus.rdata, 32'h0000_0003);
`else
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 3'(i), 32'd0);
      #1 check($sformatf("rdata_zero_a%0d", i), bus.rdata, 32'd0);
      settle();
    end
`endif

    // Reset pulse mid-run: outputs clear before the next clock, writes ignored
    cycle(1'b1, 3'd6, 32'hFFFF_FFFF);
    cycle(1'b1, 3'd5, 32'd2);
    drive(1'b1, 3'd7, 32'h0000_00FF);
    reset = 1'b1;
    #1;
    check("midrst_led_out", {24'd0, led_out}, 32'd0);
    check("midrst_counter_set", {30'd0, counter_set}, 32'd0);
    check("midrst_gpio_out", {10'd0, gpio_out}, 32'd0);
`ifdef GPIO_LED_CTRL_READBACK_EN
    check("midrst_phase", bus.rdata, 32'h8000_0000);
`endif
    settle();
    drive(1'b0, 3'd0, 32'd0);
    reset = 1'b0;
    settle();

    // Randomized traffic checked only through the scoreboard
    for (int n = 0; n < 400; n++) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd5) d = $urandom_range(0, 6);
      if (n == 200) begin
        drive(1'b1, a, d);
        reset = 1'b1;
        settle();
        drive(1'b0, 3'd0, 32'd0);
        reset = 1'b0;
        settle();
      end else begin
        cycle(1'($urandom_range(0, 1)), a, d);
      end
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
